// File: rtl/wb_pkg.sv
// Shared constants and types for the writeback arbiter.
package wb_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 1 << ADDR_W;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_SKID,
    SRC_MDU
  } wb_src_t;

endpackage

// File: rtl/writeback_arbiter_if.sv
// Bus between the ALU/MDU/decode stages, the writeback arbiter and the register bank.
// The forwarding signals exist only when WB_BYPASS_EN is defined.
interface writeback_arbiter_if #(
  parameter int DATA_W = wb_pkg::DATA_W,
  parameter int ADDR_W = wb_pkg::ADDR_W
);

  localparam int NUM_REGS = 1 << ADDR_W;

  logic              alu_valid;
  logic [ADDR_W-1:0] alu_dest;
  logic [DATA_W-1:0] alu_data;

  logic              mdu_valid;
  logic              mdu_ready;
  logic [ADDR_W-1:0] mdu_dest;
  logic [DATA_W-1:0] mdu_data;

  logic              mdu_issue;
  logic [ADDR_W-1:0] mdu_issue_dest;

  logic              write_enable;
  logic [ADDR_W-1:0] write_loc;
  logic [DATA_W-1:0] write_data;
  logic [NUM_REGS-1:0] pending;

`ifdef WB_BYPASS_EN
  logic [ADDR_W-1:0] read_rs;
  logic [ADDR_W-1:0] read_rt;
  logic [DATA_W-1:0] bank_rs_data;
  logic [DATA_W-1:0] bank_rt_data;
  logic [DATA_W-1:0] rs_fwd;
  logic [DATA_W-1:0] rt_fwd;
`endif

  modport master (
    output alu_valid, alu_dest, alu_data,
    output mdu_valid, mdu_dest, mdu_data,
    input  mdu_ready,
    output mdu_issue, mdu_issue_dest,
`ifdef WB_BYPASS_EN
    output read_rs, read_rt, bank_rs_data, bank_rt_data,
    input  rs_fwd, rt_fwd,
`endif
    input  write_enable, write_loc, write_data, pending
  );

  modport slave (
    input  alu_valid, alu_dest, alu_data,
    input  mdu_valid, mdu_dest, mdu_data,
    output mdu_ready,
    input  mdu_issue, mdu_issue_dest,
`ifdef WB_BYPASS_EN
    input  read_rs, read_rt, bank_rs_data, bank_rt_data,
    output rs_fwd, rt_fwd,
`endif
    output write_enable, write_loc, write_data, pending
  );

endinterface

// File: rtl/wb_skid_buf.sv
// One-entry holding buffer for an MDU result that lost arbitration to the ALU.
module wb_skid_buf
  import wb_pkg::*;
#(
  parameter int DATA_W = wb_pkg::DATA_W,
  parameter int ADDR_W = wb_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              drain,
  input  logic [ADDR_W-1:0] load_dest,
  input  logic [DATA_W-1:0] load_data,
  output logic              full,
  output logic [ADDR_W-1:0] dest,
  output logic [DATA_W-1:0] data
);

  logic              full_q, full_d;
  logic [ADDR_W-1:0] dest_q, dest_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    full_d = full_q;
    dest_d = dest_q;
    data_d = data_q;
    if (load) begin
      full_d = 1'b1;
      dest_d = load_dest;
      data_d = load_data;
    end else if (drain) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q <= 1'b0;
      dest_q <= '0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      dest_q <= dest_d;
      data_q <= data_d;
    end
  end

  assign full = full_q;
  assign dest = dest_q;
  assign data = data_q;

endmodule

// File: rtl/writeback_arbiter.sv
// Register-bank write port arbiter: ALU > skid-buffered MDU > fresh MDU, registered output,
// plus a pending-write scoreboard for MDU ops. Define WB_BYPASS_EN for read forwarding.
module writeback_arbiter
  import wb_pkg::*;
#(
  parameter int DATA_W = wb_pkg::DATA_W,
  parameter int ADDR_W = wb_pkg::ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  writeback_arbiter_if.slave  wb
);

  localparam int NUM_REGS = 1 << ADDR_W;

  logic              skid_full;
  logic [ADDR_W-1:0] skid_dest;
  logic [DATA_W-1:0] skid_data;
  logic              skid_load;
  logic              skid_drain;
  logic              mdu_xfer;

  wb_src_t           src;
  logic [ADDR_W-1:0] sel_dest;
  logic [DATA_W-1:0] sel_data;

  logic                write_enable_q, write_enable_d;
  logic [ADDR_W-1:0]   write_loc_q, write_loc_d;
  logic [DATA_W-1:0]   write_data_q, write_data_d;
  logic [NUM_REGS-1:0] pending_q, pending_d;

  wb_skid_buf #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .load      (skid_load),
    .drain     (skid_drain),
    .load_dest (wb.mdu_dest),
    .load_data (wb.mdu_data),
    .full      (skid_full),
    .dest      (skid_dest),
    .data      (skid_data)
  );

  assign wb.mdu_ready = !skid_full;

  // While the skid holds a result mdu_ready is low, so a fresh transfer never competes with it.
  always_comb begin
    mdu_xfer   = wb.mdu_valid && !skid_full;
    src        = SRC_NONE;
    sel_dest   = '0;
    sel_data   = '0;
    if (wb.alu_valid) begin
      src      = SRC_ALU;
      sel_dest = wb.alu_dest;
      sel_data = wb.alu_data;
    end else if (skid_full) begin
      src      = SRC_SKID;
      sel_dest = skid_dest;
      sel_data = skid_data;
    end else if (mdu_xfer) begin
      src      = SRC_MDU;
      sel_dest = wb.mdu_dest;
      sel_data = wb.mdu_data;
    end
    skid_load  = mdu_xfer && wb.alu_valid;
    skid_drain = (src == SRC_SKID);
  end

  // Pending clears when an MDU result leaves the arbiter; a same-cycle issue to that register wins.
  always_comb begin
    write_enable_d = (src != SRC_NONE) && (sel_dest != '0);
    write_loc_d    = write_loc_q;
    write_data_d   = write_data_q;
    if (write_enable_d) begin
      write_loc_d  = sel_dest;
      write_data_d = sel_data;
    end
    pending_d = pending_q;
    if (src == SRC_SKID || src == SRC_MDU) begin
      pending_d[sel_dest] = 1'b0;
    end
    if (wb.mdu_issue && wb.mdu_issue_dest != '0) begin
      pending_d[wb.mdu_issue_dest] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      write_enable_q <= 1'b0;
      write_loc_q    <= '0;
      write_data_q   <= '0;
      pending_q      <= '0;
    end else begin
      write_enable_q <= write_enable_d;
      write_loc_q    <= write_loc_d;
      write_data_q   <= write_data_d;
      pending_q      <= pending_d;
    end
  end

  assign wb.write_enable = write_enable_q;
  assign wb.write_loc    = write_loc_q;
  assign wb.write_data   = write_data_q;
  assign wb.pending      = pending_q;

`ifdef WB_BYPASS_EN
  always_comb begin
    wb.rs_fwd = wb.bank_rs_data;
    wb.rt_fwd = wb.bank_rt_data;
    if (write_enable_q && write_loc_q == wb.read_rs && wb.read_rs != '0) begin
      wb.rs_fwd = write_data_q;
    end
    if (write_enable_q && write_loc_q == wb.read_rt && wb.read_rt != '0) begin
      wb.rt_fwd = write_data_q;
    end
  end
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter with an expected-write scoreboard.
// Also exercises forwarding when built with WB_BYPASS_EN.
module tb_writeback_arbiter;
  import wb_pkg::*;

  typedef struct packed {
    logic [4:0]  loc;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  wr_t  expQ[$];
  int   passCount  = 0;
  int   totalCount = 0;

  always #5 clk = ~clk;

  writeback_arbiter_if wbIf ();

  writeback_arbiter dut (
    .clk (clk),
    .rst (rst),
    .wb  (wbIf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic applyStimulus(input logic aluV, input logic [4:0] aluD, input logic [31:0] aluX,
                               input logic mduV, input logic [4:0] mduD, input logic [31:0] mduX,
                               input logic iss, input logic [4:0] issD);
    wbIf.alu_valid      = aluV;
    wbIf.alu_dest       = aluD;
    wbIf.alu_data       = aluX;
    wbIf.mdu_valid      = mduV;
    wbIf.mdu_dest       = mduD;
    wbIf.mdu_data       = mduX;
    wbIf.mdu_issue      = iss;
    wbIf.mdu_issue_dest = issD;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
  endtask

  task automatic checkOutput(input string tag, input logic expWe);
    wr_t e;
    check({tag, ".we"}, 32'(wbIf.write_enable), 32'(expWe));
    if (expWe) begin
      if (expQ.size() == 0) begin
        totalCount++;
        $error("[TB] FAIL %s.sb observed=write expected=no_write_queued", tag);
      end else begin
        e = expQ.pop_front();
        check({tag, ".loc"}, 32'(wbIf.write_loc), 32'(e.loc));
        check({tag, ".data"}, wbIf.write_data, e.data);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    wbIf.alu_valid      = 1'b0;
    wbIf.alu_dest       = '0;
    wbIf.alu_data       = '0;
    wbIf.mdu_valid      = 1'b0;
    wbIf.mdu_dest       = '0;
    wbIf.mdu_data       = '0;
    wbIf.mdu_issue      = 1'b0;
    wbIf.mdu_issue_dest = '0;
`ifdef WB_BYPASS_EN
    wbIf.read_rs      = '0;
    wbIf.read_rt      = '0;
    wbIf.bank_rs_data = '0;
    wbIf.bank_rt_data = '0;
`endif

    repeat (2) @(posedge clk);
    #1;
    check("rst.we", 32'(wbIf.write_enable), 32'd0);
    check("rst.loc", 32'(wbIf.write_loc), 32'd0);
    check("rst.data", wbIf.write_data, 32'd0);
    check("rst.pending", wbIf.pending, 32'd0);
    check("rst.ready", 32'(wbIf.mdu_ready), 32'd1);
    rst = 1'b1;
    $display("[TB] reset released");

    // Single ALU write lasts exactly one cycle.
    expQ.push_back('{5'd5, 32'hDEADBEEF});
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    checkOutput("alu5", 1'b1);
    idle();
    checkOutput("alu5.after", 1'b0);

    // ALU and MDU collide: MDU parks in the skid.
    expQ.push_back('{5'd3, 32'h11});
    expQ.push_back('{5'd7, 32'h22});
    applyStimulus(1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'h22, 1'b0, 5'd0);
    checkOutput("coll.alu3", 1'b1);
    check("coll.ready0", 32'(wbIf.mdu_ready), 32'd0);
    idle();
    checkOutput("coll.mdu7", 1'b1);
    check("coll.ready1", 32'(wbIf.mdu_ready), 32'd1);

    // Skid holds under consecutive ALU traffic; a new MDU offer waits behind it.
    expQ.push_back('{5'd1, 32'hA1});
    expQ.push_back('{5'd2, 32'hA2});
    expQ.push_back('{5'd3, 32'hA3});
    expQ.push_back('{5'd9, 32'h99});
    expQ.push_back('{5'd10, 32'h1010});
    applyStimulus(1'b1, 5'd1, 32'hA1, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0);
    checkOutput("hold.a1", 1'b1);
    check("hold.ready.a1", 32'(wbIf.mdu_ready), 32'd0);
    applyStimulus(1'b1, 5'd2, 32'hA2, 1'b1, 5'd10, 32'h1010, 1'b0, 5'd0);
    checkOutput("hold.a2", 1'b1);
    check("hold.ready.a2", 32'(wbIf.mdu_ready), 32'd0);
    applyStimulus(1'b1, 5'd3, 32'hA3, 1'b1, 5'd10, 32'h1010, 1'b0, 5'd0);
    checkOutput("hold.a3", 1'b1);
    check("hold.ready.a3", 32'(wbIf.mdu_ready), 32'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'h1010, 1'b0, 5'd0);
    checkOutput("hold.r9", 1'b1);
    check("hold.ready.r9", 32'(wbIf.mdu_ready), 32'd1);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'h1010, 1'b0, 5'd0);
    checkOutput("hold.r10", 1'b1);
    idle();
    checkOutput("hold.quiet", 1'b0);

    // Scoreboard set/clear, including set-wins on the clearing cycle.
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12);
    check("sb.set12", wbIf.pending, 32'h0000_1000);
    idle();
    check("sb.keep12", wbIf.pending, 32'h0000_1000);
    expQ.push_back('{5'd12, 32'h1212});
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'h1212, 1'b0, 5'd0);
    checkOutput("sb.w12", 1'b1);
    check("sb.clr12", wbIf.pending, 32'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12);
    expQ.push_back('{5'd12, 32'h3434});
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'h3434, 1'b1, 5'd12);
    checkOutput("sb.w12b", 1'b1);
    check("sb.setwins", wbIf.pending, 32'h0000_1000);
    expQ.push_back('{5'd12, 32'h5656});
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'h5656, 1'b0, 5'd0);
    checkOutput("sb.w12c", 1'b1);
    check("sb.clr12b", wbIf.pending, 32'd0);

    // Pending clears when the result leaves the skid, not when it enters.
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd13);
    expQ.push_back('{5'd4, 32'h44});
    expQ.push_back('{5'd13, 32'h1313});
    applyStimulus(1'b1, 5'd4, 32'h44, 1'b1, 5'd13, 32'h1313, 1'b0, 5'd0);
    checkOutput("skidclr.alu4", 1'b1);
    check("skidclr.held", wbIf.pending, 32'h0000_2000);
    idle();
    checkOutput("skidclr.r13", 1'b1);
    check("skidclr.clr", wbIf.pending, 32'd0);

    // Register zero is never written or tracked.
    applyStimulus(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    checkOutput("r0.alu", 1'b0);
    check("r0.holdloc", 32'(wbIf.write_loc), 32'd13);
    check("r0.holddata", wbIf.write_data, 32'h1313);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0);
    check("r0.issue", wbIf.pending, 32'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hBEEF, 1'b0, 5'd0);
    checkOutput("r0.mdu", 1'b0);
    check("r0.mdu.ready", 32'(wbIf.mdu_ready), 32'd1);
    idle();
    checkOutput("r0.quiet", 1'b0);

    // Reset with a full skid and pending[4] set.
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4);
    expQ.push_back('{5'd5, 32'h55});
    applyStimulus(1'b1, 5'd5, 32'h55, 1'b1, 5'd8, 32'h88, 1'b0, 5'd0);
    checkOutput("midrst.alu5", 1'b1);
    check("midrst.pending4", wbIf.pending, 32'h0000_0010);
    check("midrst.full", 32'(wbIf.mdu_ready), 32'd0);
    wbIf.alu_valid = 1'b0;
    wbIf.mdu_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("midrst.we", 32'(wbIf.write_enable), 32'd0);
    check("midrst.loc", 32'(wbIf.write_loc), 32'd0);
    check("midrst.data", wbIf.write_data, 32'd0);
    check("midrst.pending", wbIf.pending, 32'd0);
    check("midrst.ready", 32'(wbIf.mdu_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle();
    checkOutput("midrst.post1", 1'b0);
    idle();
    checkOutput("midrst.post2", 1'b0);

`ifdef WB_BYPASS_EN
    expQ.push_back('{5'd6, 32'hAB});
    applyStimulus(1'b1, 5'd6, 32'hAB, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    checkOutput("byp.w6", 1'b1);
    wbIf.read_rs      = 5'd6;
    wbIf.read_rt      = 5'd6;
    wbIf.bank_rs_data = 32'h5555;
    wbIf.bank_rt_data = 32'h7777;
    #1;
    check("byp.rs6", wbIf.rs_fwd, 32'hAB);
    check("byp.rt6", wbIf.rt_fwd, 32'hAB);
    wbIf.read_rs = 5'd0;
    wbIf.read_rt = 5'd7;
    #1;
    check("byp.rs0", wbIf.rs_fwd, 32'h5555);
    check("byp.rt7", wbIf.rt_fwd, 32'h7777);
    idle();
    wbIf.read_rs = 5'd6;
    #1;
    check("byp.nowrite", wbIf.rs_fwd, 32'h5555);
`endif

    check("sb.empty", 32'(expQ.size()), 32'd0);
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
